// File: rtl/mmio_pkg.sv
// Shared definitions for the data-bus MMIO bridge: register offsets, STATUS layout
// and the offset decoder used by the bridge top level.
package mmio_pkg;

  localparam logic [11:0] MTIME_OFF    = 12'h000;
  localparam logic [11:0] MTIMECMP_OFF = 12'h008;
  localparam logic [11:0] TXDATA_OFF   = 12'h010;
  localparam logic [11:0] STATUS_OFF   = 12'h018;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 4;
  localparam int STAT_CNT_MSB   = 7;

  localparam logic [63:0] MMIO_BASE_DEFAULT = 64'h0000_0000_0000_1000;

  typedef enum logic [2:0] {
    REG_MTIME,
    REG_MTIMECMP,
    REG_TXDATA,
    REG_STATUS,
    REG_NONE
  } mmio_reg_e;

  function automatic mmio_reg_e decode_reg(input logic [11:0] off);
    case (off)
      MTIME_OFF:    return REG_MTIME;
      MTIMECMP_OFF: return REG_MTIMECMP;
      TXDATA_OFF:   return REG_TXDATA;
      STATUS_OFF:   return REG_STATUS;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Console transmit byte FIFO with valid/ready drain side; a push into a full FIFO
// is accepted only when the head is leaving in the same cycle.
module tx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  mem_q [DEPTH];
  logic        pop, push_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign valid_o = ~empty_o;

  assign pop     = valid_o & ready_i;
  assign push_ok = push_i & (~full_o | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  // When drained, keep presenting the byte that left last.
  assign data_o = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/data_bus_mmio_bridge.sv
// Splits core data accesses between data memory and a 4 KiB MMIO page holding a
// machine timer and a console TX FIFO, with matched one-cycle read latency.
module data_bus_mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] MMIO_BASE      = MMIO_BASE_DEFAULT[XLEN-1:0],
  parameter int unsigned     TX_FIFO_DEPTH  = 4,
  parameter int unsigned     TIMER_PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Core_MemEn,
  input  logic                Core_MemWriteEn,
  input  logic [XLEN/8-1:0]   Core_MemWriteByteEn,
  input  logic [XLEN-1:0]     Core_MemAdr,
  input  logic [XLEN-1:0]     Core_MemWriteData,
  output logic [XLEN-1:0]     Core_MemReadData,
  output logic                Dmem_En,
  output logic                Dmem_WriteEn,
  output logic [XLEN/8-1:0]   Dmem_WriteByteEn,
  output logic [XLEN-1:0]     Dmem_Adr,
  output logic [XLEN-1:0]     Dmem_WriteData,
  input  logic [XLEN-1:0]     Dmem_ReadData,
  output logic                Tx_Valid,
  output logic [7:0]          Tx_Data,
  input  logic                Tx_Ready,
  output logic                TimerIrq
);

  localparam int NB  = XLEN / 8;
  localparam int FAW = $clog2(TX_FIFO_DEPTH);
  localparam int PW  = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TIMER_PRESCALE - 1);

  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_v,
                                                  input logic [XLEN-1:0] new_v,
                                                  input logic [NB-1:0]   be);
    merge_bytes = old_v;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merge_bytes[8*i +: 8] = new_v[8*i +: 8];
    end
  endfunction

  logic            mmio, mmio_wr, mmio_rd;
  mmio_reg_e       reg_sel;
  logic [XLEN-1:0] mtime_q, mtime_d;
  logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            irq_q;
  logic            ovf_q, ovf_d;
  logic            sel_mmio_q;
  logic [XLEN-1:0] mmio_rd_data_q, mmio_rd_data;
  logic            tx_push, tx_pop, fifo_full, fifo_empty;
  logic [FAW:0]    fifo_count;
  logic [7:0]      status;

  assign mmio    = Core_MemEn & (Core_MemAdr[XLEN-1:12] == MMIO_BASE[XLEN-1:12]);
  assign mmio_wr = mmio & Core_MemWriteEn;
  assign mmio_rd = mmio & ~Core_MemWriteEn;
  assign reg_sel = decode_reg(Core_MemAdr[11:0]);

  assign Dmem_En          = Core_MemEn & ~mmio;
  assign Dmem_WriteEn     = Core_MemEn & Core_MemWriteEn & ~mmio;
  assign Dmem_WriteByteEn = Core_MemWriteByteEn;
  assign Dmem_Adr         = Core_MemAdr;
  assign Dmem_WriteData   = Core_MemWriteData;

  // A software MTIME write overrides the pending increment and restarts the prescaler.
  always_comb begin
    presc_d    = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
    mtime_d    = (presc_q == PS_LAST) ? mtime_q + 1'b1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (mmio_wr && reg_sel == REG_MTIME) begin
      mtime_d = merge_bytes(mtime_q, Core_MemWriteData, Core_MemWriteByteEn);
      presc_d = '0;
    end
    if (mmio_wr && reg_sel == REG_MTIMECMP) begin
      mtimecmp_d = merge_bytes(mtimecmp_q, Core_MemWriteData, Core_MemWriteByteEn);
    end
  end

  assign tx_push = mmio_wr & (reg_sel == REG_TXDATA) & Core_MemWriteByteEn[0];
  assign tx_pop  = Tx_Valid & Tx_Ready;

  tx_byte_fifo #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (tx_push),
    .data_i  (Core_MemWriteData[7:0]),
    .ready_i (Tx_Ready),
    .valid_o (Tx_Valid),
    .data_o  (Tx_Data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Overflow is sticky until software reads STATUS; that read still reports it.
  always_comb begin
    ovf_d = ovf_q;
    if (mmio_rd && reg_sel == REG_STATUS) ovf_d = 1'b0;
    if (tx_push && fifo_full && !tx_pop)  ovf_d = 1'b1;
  end

  always_comb begin
    status                             = '0;
    status[STAT_FULL_BIT]              = fifo_full;
    status[STAT_EMPTY_BIT]             = fifo_empty;
    status[STAT_OVF_BIT]               = ovf_q;
    status[STAT_CNT_MSB:STAT_CNT_LSB]  = 4'(fifo_count);
  end

  always_comb begin
    mmio_rd_data = '0;
    case (reg_sel)
      REG_MTIME:    mmio_rd_data = mtime_q;
      REG_MTIMECMP: mmio_rd_data = mtimecmp_q;
      REG_STATUS:   mmio_rd_data[7:0] = status;
      default:      mmio_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q        <= '0;
      mtimecmp_q     <= '1;
      presc_q        <= '0;
      irq_q          <= 1'b0;
      ovf_q          <= 1'b0;
      sel_mmio_q     <= 1'b0;
      mmio_rd_data_q <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
      ovf_q      <= ovf_d;
      sel_mmio_q <= mmio;
      if (mmio) mmio_rd_data_q <= mmio_rd_data;
    end
  end

  assign TimerIrq         = irq_q;
  assign Core_MemReadData = sel_mmio_q ? mmio_rd_data_q : Dmem_ReadData;

endmodule

// File: tb/tb_data_bus_mmio_bridge.sv
// Scoreboard bench for data_bus_mmio_bridge: expected read data and TX bytes are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_data_bus_mmio_bridge;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_MT   = BASE + 32'h000;
  localparam logic [31:0] A_CMP  = BASE + 32'h008;
  localparam logic [31:0] A_TX   = BASE + 32'h010;
  localparam logic [31:0] A_STAT = BASE + 32'h018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Core_MemEn = 1'b0;
  logic        Core_MemWriteEn = 1'b0;
  logic [3:0]  Core_MemWriteByteEn = '0;
  logic [31:0] Core_MemAdr = '0;
  logic [31:0] Core_MemWriteData = '0;
  logic [31:0] Core_MemReadData;
  logic        Dmem_En, Dmem_WriteEn;
  logic [3:0]  Dmem_WriteByteEn;
  logic [31:0] Dmem_Adr, Dmem_WriteData;
  logic [31:0] dmem_rd = 32'hCAFE_0001;
  logic        Tx_Valid;
  logic [7:0]  Tx_Data;
  logic        Tx_Ready = 1'b0;
  logic        TimerIrq;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  logic [31:0] mt_base = '0;
  int unsigned mt_cyc = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] exp_q[$];
  logic        ovf_m = 1'b0;
  logic [31:0] mem [256];

  data_bus_mmio_bridge #(
    .XLEN           (32),
    .MMIO_BASE      (BASE),
    .TX_FIFO_DEPTH  (4),
    .TIMER_PRESCALE (1)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .Core_MemEn          (Core_MemEn),
    .Core_MemWriteEn     (Core_MemWriteEn),
    .Core_MemWriteByteEn (Core_MemWriteByteEn),
    .Core_MemAdr         (Core_MemAdr),
    .Core_MemWriteData   (Core_MemWriteData),
    .Core_MemReadData    (Core_MemReadData),
    .Dmem_En             (Dmem_En),
    .Dmem_WriteEn        (Dmem_WriteEn),
    .Dmem_WriteByteEn    (Dmem_WriteByteEn),
    .Dmem_Adr            (Dmem_Adr),
    .Dmem_WriteData      (Dmem_WriteData),
    .Dmem_ReadData       (dmem_rd),
    .Tx_Valid            (Tx_Valid),
    .Tx_Data             (Tx_Data),
    .Tx_Ready            (Tx_Ready),
    .TimerIrq            (TimerIrq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered data memory, one cycle read latency.
  always @(posedge clk) begin
    if (Dmem_En) begin
      if (Dmem_WriteEn) begin
        for (int i = 0; i < 4; i++)
          if (Dmem_WriteByteEn[i]) mem[Dmem_Adr[9:2]][8*i +: 8] <= Dmem_WriteData[8*i +: 8];
      end else begin
        dmem_rd <= mem[Dmem_Adr[9:2]];
      end
    end
  end

  function automatic logic [31:0] exp_mtime();
    return mt_base + (cyc - mt_cyc);
  endfunction

  function automatic logic [31:0] exp_status(input int n, input logic ov);
    logic [31:0] s;
    s = '0;
    s[0] = (n == 4);
    s[1] = (n == 0);
    s[2] = ov;
    s[7:4] = 4'(n);
    return s;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    Core_MemEn = 1'b1; Core_MemWriteEn = 1'b1; Core_MemAdr = a;
    Core_MemWriteData = d; Core_MemWriteByteEn = be;
    @(negedge clk);
    Core_MemEn = 1'b0; Core_MemWriteEn = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Core_MemEn = 1'b1; Core_MemWriteEn = 1'b0; Core_MemAdr = a;
    @(negedge clk);
    d = Core_MemReadData;
    Core_MemEn = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    if (tx_q.size() < 4) tx_q.push_back(b);
    else ovf_m = 1'b1;
    bus_write(A_TX, {24'h0, b}, 4'hF);
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    repeat (2) @(negedge clk);
    checks++;
    if (Tx_Valid !== 1'b0 || Tx_Data !== 8'h00 || TimerIrq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%h irq=%b exp 0 00 0", Tx_Valid, Tx_Data, TimerIrq);
    end
    checks++;
    if (Core_MemReadData !== dmem_rd) begin
      failures++;
      $display("FAIL reset_readdata got=%h exp=%h", Core_MemReadData, dmem_rd);
    end
    reset = 1'b1;
    mt_base = '0; mt_cyc = cyc;
    exp_q.push_back(exp_status(0, 1'b0));
    bus_read(A_STAT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_status got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_timer();
    logic [31:0] got, exp;
    bit done;
    repeat (10) @(negedge clk);
    exp_q.push_back(exp_mtime());
    bus_read(A_MT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL mtime_count got=%h exp=%h", got, exp);
    end
    bus_write(A_CMP, 32'd20, 4'hF);
    exp_q.push_back(32'd20);
    bus_read(A_CMP, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL mtimecmp_rd got=%h exp=%h", got, exp);
    end
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (exp_mtime() == 32'd20) begin
        checks++;
        if (TimerIrq !== 1'b0) begin
          failures++;
          $display("FAIL irq_early got=%b exp=0", TimerIrq);
        end
      end
      if (exp_mtime() == 32'd21) begin
        done = 1'b1;
        checks++;
        if (TimerIrq !== 1'b1) begin
          failures++;
          $display("FAIL irq_rise got=%b exp=1", TimerIrq);
        end
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL irq_timeout got=%h exp=21", exp_mtime());
    end
    mt_base = 32'd0; mt_cyc = cyc + 1;
    bus_write(A_MT, 32'd0, 4'hF);
    checks++;
    if (TimerIrq !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold got=%b exp=1", TimerIrq);
    end
    @(negedge clk);
    checks++;
    if (TimerIrq !== 1'b0) begin
      failures++;
      $display("FAIL irq_drop got=%b exp=0", TimerIrq);
    end
  endtask

  task automatic test_timer_collision();
    logic [31:0] got, exp;
    mt_base = 32'h100; mt_cyc = cyc + 1;
    bus_write(A_MT, 32'h100, 4'hF);
    exp_q.push_back(exp_mtime());
    bus_read(A_MT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got !== 32'h100) begin
      failures++;
      $display("FAIL mtime_collision got=%h exp=%h", got, exp);
    end
    bus_write(A_CMP, 32'h1234_5678, 4'b0011);
    bus_write(A_CMP, 32'hAABB_CCDD, 4'b1100);
    exp_q.push_back(32'hAABB_5678);
    bus_read(A_CMP, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cmp_byte_en got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] got, exp;
    logic [31:0] addrs [2];
    logic [31:0] datas [2];
    addrs[0] = 32'h20; datas[0] = 32'hDEAD_BEEF;
    addrs[1] = 32'h24; datas[1] = 32'h1357_9BDF;
    for (int k = 0; k < 2; k++) begin
      Core_MemEn = 1'b1; Core_MemWriteEn = 1'b1; Core_MemAdr = addrs[k];
      Core_MemWriteData = datas[k]; Core_MemWriteByteEn = 4'hF;
      #1;
      checks++;
      if (Dmem_En !== 1'b1 || Dmem_WriteEn !== 1'b1 || Dmem_Adr !== addrs[k] || Dmem_WriteData !== datas[k]) begin
        failures++;
        $display("FAIL dmem_write_ctl got en=%b we=%b adr=%h exp 1 1 %h", Dmem_En, Dmem_WriteEn, Dmem_Adr, addrs[k]);
      end
      @(negedge clk);
      Core_MemWriteEn = 1'b0;
      exp_q.push_back(datas[k]);
      #1;
      checks++;
      if (Dmem_En !== 1'b1 || Dmem_WriteEn !== 1'b0) begin
        failures++;
        $display("FAIL dmem_read_ctl got en=%b we=%b exp 1 0", Dmem_En, Dmem_WriteEn);
      end
      @(negedge clk);
      got = Core_MemReadData;
      Core_MemEn = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL dmem_readback got=%h exp=%h", got, exp);
      end
    end
    Core_MemEn = 1'b1; Core_MemWriteEn = 1'b1; Core_MemAdr = BASE + 32'h30;
    Core_MemWriteData = 32'h5555_5555;
    #1;
    checks++;
    if (Dmem_En !== 1'b0 || Dmem_WriteEn !== 1'b0) begin
      failures++;
      $display("FAIL mmio_no_dmem got en=%b we=%b exp 0 0", Dmem_En, Dmem_WriteEn);
    end
    @(negedge clk);
    Core_MemEn = 1'b0; Core_MemWriteEn = 1'b0;
    exp_q.push_back(32'h0);
    bus_read(BASE + 32'h30, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL unmapped_rd got=%h exp=%h", got, exp);
    end
    exp_q.push_back(32'h0);
    bus_read(BASE + 32'h004, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL misaligned_rd got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] got, exp;
    Tx_Ready = 1'b0;
    bus_write(A_TX, 32'h99, 4'b1110);
    exp_q.push_back(32'h0);
    bus_read(A_TX, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL txdata_rd got=%h exp=%h", got, exp);
    end
    exp_q.push_back(exp_status(tx_q.size(), ovf_m));
    bus_read(A_STAT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL no_push_be got=%h exp=%h", got, exp);
    end
    for (int b = 8'h41; b <= 8'h45; b++) tx_write(8'(b));
    checks++;
    if (Tx_Valid !== 1'b1 || Tx_Data !== tx_q[0]) begin
      failures++;
      $display("FAIL head_stable got valid=%b data=%h exp 1 %h", Tx_Valid, Tx_Data, tx_q[0]);
    end
    exp_q.push_back(exp_status(tx_q.size(), ovf_m));
    ovf_m = 1'b0;
    bus_read(A_STAT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got !== 32'h45) begin
      failures++;
      $display("FAIL status_ovf got=%h exp=%h", got, exp);
    end
    exp_q.push_back(exp_status(tx_q.size(), ovf_m));
    bus_read(A_STAT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL status_ovf_clr got=%h exp=%h", got, exp);
    end
    Tx_Ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) begin
      if (Tx_Valid) begin
        checks++;
        if (Tx_Data !== tx_q[0]) begin
          failures++;
          $display("FAIL drain_byte got=%h exp=%h", Tx_Data, tx_q[0]);
        end
        void'(tx_q.pop_front());
      end
      @(negedge clk);
    end
    Tx_Ready = 1'b0;
    checks++;
    if (tx_q.size() != 0 || Tx_Valid !== 1'b0 || Tx_Data !== 8'h44) begin
      failures++;
      $display("FAIL drain_end got valid=%b data=%h left=%0d exp 0 44 0", Tx_Valid, Tx_Data, tx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    Tx_Ready = 1'b0;
    for (int b = 8'h50; b <= 8'h53; b++) tx_write(8'(b));
    checks++;
    if (Tx_Data !== tx_q[0]) begin
      failures++;
      $display("FAIL full_head got=%h exp=%h", Tx_Data, tx_q[0]);
    end
    void'(tx_q.pop_front());
    tx_q.push_back(8'h5A);
    Tx_Ready = 1'b1;
    bus_write(A_TX, 32'h5A, 4'hF);
    Tx_Ready = 1'b0;
    exp_q.push_back(exp_status(tx_q.size(), ovf_m));
    bus_read(A_STAT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got !== 32'h41) begin
      failures++;
      $display("FAIL pushpop_status got=%h exp=%h", got, exp);
    end
    Tx_Ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) begin
      if (Tx_Valid) begin
        checks++;
        if (Tx_Data !== tx_q[0]) begin
          failures++;
          $display("FAIL pushpop_byte got=%h exp=%h", Tx_Data, tx_q[0]);
        end
        void'(tx_q.pop_front());
      end
      @(negedge clk);
    end
    Tx_Ready = 1'b0;
    checks++;
    if (tx_q.size() != 0 || Tx_Valid !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_drain got valid=%b left=%0d exp 0 0", Tx_Valid, tx_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] got, exp;
    Tx_Ready = 1'b0;
    for (int b = 8'h61; b <= 8'h63; b++) tx_write(8'(b));
    bus_write(A_CMP, 32'd20, 4'hF);
    bus_write(A_MT, 32'd50, 4'hF);
    repeat (2) @(negedge clk);
    checks++;
    if (TimerIrq !== 1'b1 || Tx_Valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got irq=%b valid=%b exp 1 1", TimerIrq, Tx_Valid);
    end
    Core_MemEn = 1'b1; Core_MemWriteEn = 1'b0; Core_MemAdr = A_STAT;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (Tx_Valid !== 1'b0 || TimerIrq !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got valid=%b irq=%b exp 0 0", Tx_Valid, TimerIrq);
    end
    checks++;
    if (Core_MemReadData !== dmem_rd) begin
      failures++;
      $display("FAIL reset_inflight got=%h exp=%h", Core_MemReadData, dmem_rd);
    end
    Core_MemEn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mt_base = '0; mt_cyc = cyc;
    tx_q.delete();
    ovf_m = 1'b0;
    exp_q.push_back(exp_status(0, 1'b0));
    bus_read(A_STAT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL post_reset_status got=%h exp=%h", got, exp);
    end
    exp_q.push_back(exp_mtime());
    bus_read(A_MT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got > 32'd5) begin
      failures++;
      $display("FAIL post_reset_mtime got=%h exp=%h", got, exp);
    end
    exp_q.push_back(32'hFFFF_FFFF);
    bus_read(A_CMP, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL post_reset_cmp got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_timer_collision();
    test_passthrough();
    test_fifo_overflow();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
